// File: rtl/aram_arb_pkg.sv
// Shared types for the audio RAM arbiter: owner tags, lock state and response tags.
package aram_arb_pkg;

  localparam int ARAM_ADDR_W = 16;
  localparam int ARAM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DSP  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } resp_tag_t;

  // Only reads travel down the response pipe; writes complete on ack.
  function automatic resp_tag_t make_tag(input owner_e owner, input logic we);
    resp_tag_t t;
    t.valid = (owner != OWN_NONE) && !we;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/aram_resp_pipe.sv
// Tag delay line matching the RAM read latency; the tail names who gets the returning byte.
module aram_resp_pipe
  import aram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  resp_tag_t i_tag,
  output resp_tag_t o_tag
);

  resp_tag_t r_stage [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/aram_arbiter.sv
// Single-port ARAM arbiter, DSP > CPU with DSP lock for BRR block fetches.
// Optional CPU anti-starvation counter enabled by defining ARAM_ARB_STARVE_GUARD_EN.
module aram_arbiter
  import aram_arb_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dsp_req,
  input  logic [ARAM_ADDR_W-1:0] dsp_addr,
  input  logic [ARAM_DATA_W-1:0] dsp_wdata,
  input  logic                   dsp_we,
  input  logic                   dsp_lock,
  output logic                   dsp_ack,
  output logic                   dsp_rvalid,
  output logic [ARAM_DATA_W-1:0] dsp_rdata,
  input  logic                   cpu_req,
  input  logic [ARAM_ADDR_W-1:0] cpu_addr,
  input  logic [ARAM_DATA_W-1:0] cpu_wdata,
  input  logic                   cpu_we,
  output logic                   cpu_ack,
  output logic                   cpu_rvalid,
  output logic [ARAM_DATA_W-1:0] cpu_rdata,
  output logic [ARAM_ADDR_W-1:0] ram_address,
  output logic [ARAM_DATA_W-1:0] ram_wdata,
  output logic                   ram_write_enable,
  input  logic [ARAM_DATA_W-1:0] ram_rdata,
  output lock_e                  o_dbg_lock_state
);

  if (RAM_LATENCY < 1 || RAM_LATENCY > 4 || MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_bad_param
    $error("aram_arbiter: RAM_LATENCY must be 1..4 and MAX_WAIT 1..7");
  end

  // Handshake: a requester holds req/addr/wdata/we until it sees ack high in the
  // same cycle; ack is combinational and the access is issued on that clock edge.
  // Dropping req before ack is legal and issues nothing.

  lock_e                  r_lock;
  owner_e                 w_owner;
  logic                   w_locked;
  logic                   w_force_cpu;
  logic [ARAM_ADDR_W-1:0] w_addr;
  logic [ARAM_DATA_W-1:0] w_wdata;
  logic                   w_we;
  resp_tag_t              w_tail;

`ifdef ARAM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);
  logic [2:0] r_wait;

  assign w_force_cpu = cpu_req && (r_wait == WAIT_MAX);

  // Counts consecutive cycles the CPU asked and lost; saturates at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait <= '0;
    end else if (!cpu_req || (w_owner == OWN_CPU)) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + 3'd1;
    end
  end
`else
  assign w_force_cpu = 1'b0;
`endif

  // The lock only binds while dsp_lock is still high; its release cycle arbitrates normally.
  assign w_locked = (r_lock == LOCK_HELD) && dsp_lock;

  always_comb begin
    w_owner = OWN_NONE;
    if (reset) begin
      w_owner = OWN_NONE;
    end else if (w_force_cpu) begin
      w_owner = OWN_CPU;
    end else if (w_locked) begin
      w_owner = dsp_req ? OWN_DSP : OWN_NONE;
    end else if (dsp_req) begin
      w_owner = OWN_DSP;
    end else if (cpu_req) begin
      w_owner = OWN_CPU;
    end
  end

  assign dsp_ack = (w_owner == OWN_DSP);
  assign cpu_ack = (w_owner == OWN_CPU);

  always_comb begin
    w_addr  = dsp_addr;
    w_wdata = dsp_wdata;
    w_we    = dsp_we;
    if (w_owner == OWN_CPU) begin
      w_addr  = cpu_addr;
      w_wdata = cpu_wdata;
      w_we    = cpu_we;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock <= LOCK_FREE;
    end else begin
      case (r_lock)
        LOCK_FREE: if ((w_owner == OWN_DSP) && dsp_lock) r_lock <= LOCK_HELD;
        LOCK_HELD: if (!dsp_lock) r_lock <= LOCK_FREE;
        default:   r_lock <= LOCK_FREE;
      endcase
    end
  end

  assign o_dbg_lock_state = r_lock;

  // With no owner the address and data hold; only the write strobe drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_address      <= '0;
      ram_wdata        <= '0;
      ram_write_enable <= 1'b0;
    end else if (w_owner != OWN_NONE) begin
      ram_address      <= w_addr;
      ram_wdata        <= w_wdata;
      ram_write_enable <= w_we;
    end else begin
      ram_write_enable <= 1'b0;
    end
  end

  aram_resp_pipe #(.DEPTH(RAM_LATENCY)) u_resp_pipe (
    .clock (clock),
    .reset (reset),
    .i_tag (make_tag(w_owner, w_we)),
    .o_tag (w_tail)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      dsp_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      dsp_rdata  <= '0;
      cpu_rdata  <= '0;
    end else begin
      dsp_rvalid <= w_tail.valid && (w_tail.owner == OWN_DSP);
      cpu_rvalid <= w_tail.valid && (w_tail.owner == OWN_CPU);
      if (w_tail.valid && (w_tail.owner == OWN_DSP)) dsp_rdata <= ram_rdata;
      if (w_tail.valid && (w_tail.owner == OWN_CPU)) cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_aram_arbiter.sv
// Directed bench for aram_arbiter: vector table for grant/lock rules plus multi-cycle sequences.
module tb_aram_arbiter;
  import aram_arb_pkg::*;

  localparam int LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        dsp_req, dsp_we, dsp_lock, dsp_ack, dsp_rvalid;
  logic [15:0] dsp_addr;
  logic [7:0]  dsp_wdata, dsp_rdata;
  logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_write_enable;
  lock_e       lock_state;

  aram_arbiter #(.RAM_LATENCY(LAT), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata), .dsp_we(dsp_we),
    .dsp_lock(dsp_lock), .dsp_ack(dsp_ack), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_write_enable(ram_write_enable),
    .ram_rdata(ram_rdata), .o_dbg_lock_state(lock_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Latency-1 RAM: data for the address presented this cycle, captured by the DUT at the edge.
  assign ram_rdata = mem[ram_address];
  always @(posedge clock) if (ram_write_enable) mem[ram_address] <= ram_wdata;

  // ---------------- check / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0] dsp_exp_q[$];
  logic [7:0] cpu_exp_q[$];
  int         dsp_cyc_q[$];
  int         cpu_cyc_q[$];

  always @(negedge clock) begin
    if (reset) begin
      dsp_exp_q.delete(); dsp_cyc_q.delete();
      cpu_exp_q.delete(); cpu_cyc_q.delete();
    end else begin
      chk("one_grant_per_cycle", 32'(dsp_ack & cpu_ack), 32'd0);
      if (dsp_rvalid) begin
        if (dsp_exp_q.size() == 0) chk("dsp_spurious_rvalid", 32'd1, 32'd0);
        else begin
          chk("dsp_rdata_sb", 32'(dsp_rdata), 32'(dsp_exp_q.pop_front()));
          chk("dsp_rvalid_cycle", 32'(cyc), 32'(dsp_cyc_q.pop_front()));
        end
      end
      if (cpu_rvalid) begin
        if (cpu_exp_q.size() == 0) chk("cpu_spurious_rvalid", 32'd1, 32'd0);
        else begin
          chk("cpu_rdata_sb", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
          chk("cpu_rvalid_cycle", 32'(cyc), 32'(cpu_cyc_q.pop_front()));
        end
      end
      if (dsp_ack) begin
        if (dsp_we) ref_mem[dsp_addr] = dsp_wdata;
        else begin dsp_exp_q.push_back(ref_mem[dsp_addr]); dsp_cyc_q.push_back(cyc + 1 + LAT); end
      end
      if (cpu_ack) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else begin cpu_exp_q.push_back(ref_mem[cpu_addr]); cpu_cyc_q.push_back(cyc + 1 + LAT); end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_dsp(input logic req, input logic lock, input logic we,
                           input logic [15:0] addr, input logic [7:0] wdata);
    dsp_req = req; dsp_lock = lock; dsp_we = we; dsp_addr = addr; dsp_wdata = wdata;
  endtask

  task automatic drive_cpu(input logic req, input logic we,
                           input logic [15:0] addr, input logic [7:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic idle_cycles(input int n);
    drive_dsp(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    repeat (n) tick();
  endtask

  typedef struct {
    logic  d_req;
    logic  d_lock;
    logic  c_req;
    logic  e_dack;
    logic  e_cack;
    lock_e e_lock;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int   dsp_idx;
    int   k;
    logic exp_c;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LOCK_FREE};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, LOCK_FREE};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, LOCK_FREE};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, LOCK_HELD};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LOCK_HELD};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, LOCK_HELD};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, LOCK_FREE};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, LOCK_HELD};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, LOCK_FREE};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, LOCK_FREE};

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = init_val(16'(i));
      ref_mem[i] = init_val(16'(i));
    end

    reset = 1'b1;
    drive_dsp(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    tick(); tick();
    @(negedge clock);
    chk("rst_dsp_ack", 32'(dsp_ack), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_dsp_rvalid", 32'(dsp_rvalid), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_ram_we", 32'(ram_write_enable), 0);
    chk("rst_ram_addr", 32'(ram_address), 0);
    chk("rst_dsp_rdata", 32'(dsp_rdata), 0);
    chk("rst_lock", 32'(lock_state), 32'(LOCK_FREE));
    tick();
    reset = 1'b0;

    // 1: simultaneous reads, DSP first, responses in issue order
    drive_dsp(1'b1, 1'b0, 1'b0, 16'h0200, 8'h0);
    drive_cpu(1'b1, 1'b0, 16'h0300, 8'h0);
    @(negedge clock);
    chk("t1_dsp_ack", 32'(dsp_ack), 1);
    chk("t1_cpu_wait", 32'(cpu_ack), 0);
    tick();
    drive_dsp(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clock);
    chk("t1_cpu_ack", 32'(cpu_ack), 1);
    chk("t1_ram_addr", 32'(ram_address), 32'h0200);
    tick();
    drive_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clock);
    chk("t1_dsp_rvalid", 32'(dsp_rvalid), 1);
    chk("t1_dsp_rdata", 32'(dsp_rdata), 32'hA7);
    chk("t1_cpu_rvalid_early", 32'(cpu_rvalid), 0);
    tick();
    @(negedge clock);
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'hA6);
    chk("t1_dsp_rvalid_once", 32'(dsp_rvalid), 0);
    tick();

    // 2: CPU write then read of the same address
    drive_cpu(1'b1, 1'b1, 16'h1234, 8'h55);
    @(negedge clock);
    chk("t2_wr_ack", 32'(cpu_ack), 1);
    tick();
    drive_cpu(1'b1, 1'b0, 16'h1234, 8'h00);
    @(negedge clock);
    chk("t2_rd_ack", 32'(cpu_ack), 1);
    chk("t2_ram_we", 32'(ram_write_enable), 1);
    chk("t2_ram_addr", 32'(ram_address), 32'h1234);
    chk("t2_ram_wdata", 32'(ram_wdata), 32'h55);
    tick();
    drive_cpu(1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clock);
    chk("t2_no_wr_rvalid", 32'(cpu_rvalid), 0);
    tick();
    @(negedge clock);
    chk("t2_rd_rvalid", 32'(cpu_rvalid), 1);
    chk("t2_rd_data", 32'(cpu_rdata), 32'h55);
    tick();

    // grant/lock vector table
    for (int i = 0; i < 10; i++) begin
      drive_dsp(vecs[i].d_req, vecs[i].d_lock, 1'b0, 16'h1000, 8'h0);
      drive_cpu(vecs[i].c_req, 1'b0, 16'h1100, 8'h0);
      @(negedge clock);
      chk($sformatf("vec%0d_dsp_ack", i), 32'(dsp_ack), 32'(vecs[i].e_dack));
      chk($sformatf("vec%0d_cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].e_cack));
      tick();
      chk($sformatf("vec%0d_lock", i), 32'(lock_state), 32'(vecs[i].e_lock));
    end
    idle_cycles(3);

    // 3: locked 9-byte BRR fetch with CPU waiting
    drive_cpu(1'b1, 1'b0, 16'h0400, 8'h0);
    dsp_idx = 0;
    k = 0;
    while (dsp_idx < 9 && k < 30) begin
      drive_dsp(1'b1, 1'b1, 1'b0, 16'h4000 + 16'(dsp_idx), 8'h0);
      @(negedge clock);
`ifdef ARAM_ARB_STARVE_GUARD_EN
      exp_c = (k % 5 == 4);
`else
      exp_c = 1'b0;
`endif
      chk("t3_cpu_ack", 32'(cpu_ack), 32'(exp_c));
      chk("t3_dsp_ack", 32'(dsp_ack), 32'(!exp_c));
      if (dsp_ack) dsp_idx++;
      tick();
      k++;
    end
    chk("t3_dsp_bytes", 32'(dsp_idx), 9);
    drive_dsp(1'b0, 1'b1, 1'b0, 16'h0, 8'h0);
    @(negedge clock);
    chk("t3_locked_idle_cpu", 32'(cpu_ack), 0);
    chk("t3_lock_held", 32'(lock_state), 32'(LOCK_HELD));
    tick();
    drive_dsp(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clock);
    chk("t3_cpu_after_unlock", 32'(cpu_ack), 1);
    tick();
    idle_cycles(3);

    // 4: both requesters held continuously
    drive_dsp(1'b1, 1'b0, 1'b0, 16'h0700, 8'h0);
    drive_cpu(1'b1, 1'b0, 16'h0800, 8'h0);
    for (int j = 0; j < 15; j++) begin
      @(negedge clock);
`ifdef ARAM_ARB_STARVE_GUARD_EN
      exp_c = (j % 5 == 4);
`else
      exp_c = 1'b0;
`endif
      chk("t4_cpu_ack", 32'(cpu_ack), 32'(exp_c));
      chk("t4_dsp_ack", 32'(dsp_ack), 32'(!exp_c));
      tick();
    end
    idle_cycles(3);

    // 5: reset right after a DSP read issue discards its response
    drive_dsp(1'b1, 1'b0, 1'b0, 16'h0500, 8'h0);
    @(negedge clock);
    chk("t5_dsp_ack", 32'(dsp_ack), 1);
    tick();
    drive_dsp(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("t5_dsp_rvalid", 32'(dsp_rvalid), 0);
    chk("t5_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("t5_dsp_rdata", 32'(dsp_rdata), 0);
    chk("t5_cpu_rdata", 32'(cpu_rdata), 0);
    chk("t5_ram_we", 32'(ram_write_enable), 0);
    chk("t5_ram_addr", 32'(ram_address), 0);
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clock);
      chk("t5_no_late_rvalid", 32'(dsp_rvalid), 0);
    end
    tick();
    drive_dsp(1'b1, 1'b0, 1'b0, 16'h0600, 8'h0);
    @(negedge clock);
    chk("t5_resume_ack", 32'(dsp_ack), 1);
    tick();
    idle_cycles(3);

    // 6: idle after a write keeps the write strobe low
    drive_cpu(1'b1, 1'b1, 16'h2000, 8'hC3);
    @(negedge clock);
    chk("t6_wr_ack", 32'(cpu_ack), 1);
    tick();
    idle_cycles(1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      chk("t6_idle_we", 32'(ram_write_enable), 0);
      chk("t6_idle_acks", 32'({dsp_ack, cpu_ack}), 0);
      chk("t6_idle_rvalids", 32'({dsp_rvalid, cpu_rvalid}), 0);
      tick();
    end
    drive_dsp(1'b1, 1'b0, 1'b0, 16'h2000, 8'h0);
    @(negedge clock);
    chk("t6_readback_ack", 32'(dsp_ack), 1);
    tick();
    idle_cycles(4);

    chk("dsp_queue_drained", 32'(dsp_exp_q.size()), 0);
    chk("cpu_queue_drained", 32'(cpu_exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
